// File: rtl/twofish_pkg.sv
// twofish_pkg: shared constants and types for the Twofish key schedule.
// Holds the RS matrix, the GF(2^8) reduction polynomial and the s_key_gen FSM states.
package twofish_pkg;

  // Reduction polynomial x^8 + x^6 + x^3 + x^2 + 1; the x^8 term is implicit.
  localparam logic [7:0] GF_POLY = 8'h4D;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Reed-Solomon matrix, RS[row][col]; row 0 / column 0 is the leftmost byte.
  localparam logic [0:3][0:7][7:0] RS = {
    64'h01A4_5587_5A58_DB9E,
    64'hA456_82F3_1EC6_68E5,
    64'h02A1_FCC1_47AE_3D19,
    64'hA455_875A_58DB_9E03
  };

  // Multiply a field element by x, reducing modulo GF_POLY.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier, reduction polynomial 0x14D.
// Shift-and-add over the bits of b_i; the shifted operand is reduced each step.
module gf256_mul
  import twofish_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] sh;

  // Accumulate a_i * x^i for every set bit i of b_i.
  always_comb begin
    p_o = '0;
    sh  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) p_o = p_o ^ sh;
      sh = gf_xtime(sh);
    end
  end

endmodule

// File: rtl/s_key_gen.sv
// s_key_gen: iterative Twofish S-box key word generator (RS matrix, COLS bytes/cycle).
// Optional TWOFISH_SKEY_MASK_EN: hide s0/s1 (drive zero) while s_valid is low.
module s_key_gen
  import twofish_pkg::*;
#(
  parameter int COLS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         s_valid,
  output logic [31:0]  s0,
  output logic [31:0]  s1
);

  localparam int STEPS = 16 / COLS;
  localparam int CW    = $clog2(STEPS);

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [31:0]    acc0_q, acc0_d;
  logic [31:0]    acc1_q, acc1_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [3:0]                 base;
  logic [COLS-1:0][7:0]       mb;
  logic [COLS-1:0][3:0][7:0]  coef;
  logic [COLS-1:0][3:0][7:0]  prod;
  logic [31:0]                fold;

  assign base = 4'(int'(cnt_q) * COLS);

  // Pick this step's key bytes and the RS column coefficients they meet.
  always_comb begin : sel
    logic [3:0] idx;
    idx  = '0;
    mb   = '0;
    coef = '0;
    for (int k = 0; k < COLS; k++) begin
      idx   = base + 4'(k);
      mb[k] = key_q[{idx, 3'b000} +: 8];
      for (int j = 0; j < 4; j++) begin
        coef[k][j] = RS[j][idx[2:0]];
      end
    end
  end

  for (genvar gk = 0; gk < COLS; gk++) begin : g_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_row
      gf256_mul u_mul (
        .a_i (coef[gk][gj]),
        .b_i (mb[gk]),
        .p_o (prod[gk][gj])
      );
    end
  end

  // XOR all column products of this step into one 32-bit partial word.
  always_comb begin
    fold = '0;
    for (int k = 0; k < COLS; k++) begin
      for (int j = 0; j < 4; j++) begin
        fold[8*j +: 8] = fold[8*j +: 8] ^ prod[k][j];
      end
    end
  end

  // Next-state, accumulator and handshake logic.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    acc0_d    = acc0_q;
    acc1_d    = acc1_q;
    cnt_d     = cnt_q;
    key_ready = 1'b0;
    s_valid   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        key_ready = 1'b1;
        s_valid   = (state_q == DONE);
        if (key_valid) begin
          key_d   = key;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (base[3]) acc1_d = acc1_q ^ fold;
        else         acc0_d = acc0_q ^ fold;
        if (cnt_q == CW'(STEPS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, key and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TWOFISH_SKEY_MASK_EN
  assign s0 = s_valid ? acc0_q : 32'h0;
  assign s1 = s_valid ? acc1_q : 32'h0;
`else
  assign s0 = acc0_q;
  assign s1 = acc1_q;
`endif

endmodule

// File: tb/tb_s_key_gen.sv
// tb_s_key_gen: checks s_key_gen for COLS = 1, 2, 4, 8 against a software RS model.
// Four instances share clk/rst/key; each has its own key_valid.
module tb_s_key_gen;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [127:0]      key = '0;
  logic [3:0]        kv  = '0;
  logic [3:0]        kr, sv;
  logic [3:0][31:0]  s0w, s1w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    s_key_gen #(.COLS(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (kv[g]),
      .key_ready (kr[g]),
      .key       (key),
      .s_valid   (sv[g]),
      .s0        (s0w[g]),
      .s1        (s1w[g])
    );
  end

  int total  = 0;
  int passed = 0;
  bit go     = 1'b0;

  bit [7:0] RSB [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  // Carry-less product, then polynomial long division by 0x14D.
  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h014D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] rsw(input logic [127:0] k, input int half);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < 8; c++)
        r[8*j +: 8] = r[8*j +: 8] ^ gmul(RSB[j][c], k[8*(8*half + c) +: 8]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
  endtask

  // Transaction-level model: cycles left in a computation, and the expected result.
  int          busy  [4] = '{default: 0};
  bit          have  [4] = '{default: 1'b0};
  bit          fresh [4] = '{default: 1'b1};
  logic [31:0] e0    [4] = '{default: '0};
  logic [31:0] e1    [4] = '{default: '0};

  // Advance the model on each clock edge, or clear it immediately on reset.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        busy[i]  <= 0;
        have[i]  <= 1'b0;
        fresh[i] <= 1'b1;
        e0[i]    <= '0;
        e1[i]    <= '0;
      end else if (busy[i] > 0) begin
        busy[i] <= busy[i] - 1;
        have[i] <= (busy[i] == 1);
      end else if (kv[i]) begin
        busy[i]  <= 16 >> i;
        have[i]  <= 1'b0;
        fresh[i] <= 1'b0;
        e0[i]    <= rsw(key, 0);
        e1[i]    <= rsw(key, 1);
      end
    end
  end

  // Compare every instance against the model away from the active edge.
  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ready[%0d]", i), 32'(kr[i]), 32'(busy[i] == 0));
        chk($sformatf("valid[%0d]", i), 32'(sv[i]), 32'(have[i]));
        if (have[i] || fresh[i]) begin
          chk($sformatf("s0[%0d]", i), s0w[i], e0[i]);
          chk($sformatf("s1[%0d]", i), s1w[i], e1[i]);
        end
`ifdef TWOFISH_SKEY_MASK_EN
        else begin
          chk($sformatf("s0_mask[%0d]", i), s0w[i], 32'h0);
          chk($sformatf("s1_mask[%0d]", i), s1w[i], 32'h0);
        end
`endif
      end
    end
  end

  // Offer one key to instance i, then check latency and literal result.
  task automatic send(input int i, input logic [127:0] k,
                      input logic [31:0] x0, input logic [31:0] x1);
    int n;
    n = 0;
    while (!kr[i] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    key   = k;
    kv[i] = 1'b1;
    @(posedge clk); #1;
    kv[i] = 1'b0;
    n = 0;
    while (!sv[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency[%0d]", i), 32'(n), 32'(16 >> i));
    chk($sformatf("lit_s0[%0d]", i), s0w[i], x0);
    chk($sformatf("lit_s1[%0d]", i), s1w[i], x1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k01, k02, k11, k801, ka;
    k01  = 128'h01;
    k02  = 128'h02;
    k11  = 128'h0100;
    k801 = 128'h01 << 64;

    // Pin the model to hand-computed values.
    chk("pin_zero",  rsw('0, 0),   32'h00000000);
    chk("pin_m0_s0", rsw(k01, 0),  32'hA402A401);
    chk("pin_m0_s1", rsw(k01, 1),  32'h00000000);
    chk("pin_m8_s1", rsw(k801, 1), 32'hA402A401);
    chk("pin_m0x2",  rsw(k02, 0),  32'h05040502);
    chk("pin_m1",    rsw(k11, 0),  32'h55A156A4);

    #1 go = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(0, '0,   32'h0,        32'h0);
    send(0, k01,  32'hA402A401, 32'h0);
    send(0, k801, 32'h0,        32'hA402A401);
    for (int i = 0; i < 4; i++) send(i, k02, 32'h05040502, 32'h0);

    // Hold key_valid high on instance 0 with a changing key.
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      key   = rnd128();
      kv[0] = 1'b1;
    end
    kv[0] = 1'b0;

    // Pulses on instance 2 during RUN must be ignored.
    ka = rnd128();
    @(posedge clk); #1;
    key   = ka;
    kv[2] = 1'b1;
    @(posedge clk); #1;
    kv[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      key   = rnd128();
      kv[2] = c[0];
      @(posedge clk); #1;
    end
    kv[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_s0", s0w[2], rsw(ka, 0));
    chk("ign_s1", s1w[2], rsw(ka, 1));

    // Reset at cycle 5 of RUN on instance 0.
    repeat (20) @(posedge clk);
    #1;
    key   = rnd128();
    kv[0] = 1'b1;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_s0",    s0w[0], 32'h0);
    chk("rst_s1",    s1w[0], 32'h0);
    chk("rst_ready", 32'(kr[0]), 32'h1);
    chk("rst_valid", 32'(sv[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, k02, 32'h05040502, 32'h0);

    // Random keys on every instance.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        ka = rnd128();
        send(i, ka, rsw(ka, 0), rsw(ka, 1));
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
